// File: rtl/sha256_block_sequencer_if.sv
// Stream-side bundle of the sha256 block sequencer: the 32-bit message word
// input stream and the held digest output channel.
interface sha256_block_sequencer_if #(
  parameter int CNT_W = 16
) ();
  // message word stream into the sequencer
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  // digest channel out of the sequencer
  logic             m_valid;
  logic             m_ready;
  logic [255:0]     m_digest;
  logic [CNT_W-1:0] m_blocks;

  // sequencer side: consumes words, produces digests
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_digest, m_blocks
  );

  // environment side: supplies words, consumes digests
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_digest, m_blocks
  );
endinterface

// File: rtl/sha256_block_sequencer.sv
// Streaming front-end for a sha256 core: packs 16 message words into a
// 512-bit block, pulses init (first block) or next (later blocks), waits for
// the core with a timeout, and holds the final digest until it is accepted.
module sha256_block_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  sha256_block_sequencer_if.slave  bus,
  output logic                     core_init,
  output logic                     core_next,
  output logic [511:0]             core_block,
  input  logic                     core_ready,
  input  logic [255:0]             core_digest,
  input  logic                     core_digest_valid,
  output logic                     busy,
  output logic                     err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [15:0][31:0]  block_q, block_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               first_q, first_d;
  logic               last_blk_q, last_blk_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               s_ready_q, s_ready_d;
  logic               init_q, init_d;
  logic               next_q, next_d;
  logic               m_valid_q, m_valid_d;
  logic [255:0]       m_digest_q, m_digest_d;
  logic [CNT_W-1:0]   m_blocks_q, m_blocks_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    block_d    = block_q;
    wcnt_d     = wcnt_q;
    first_d    = first_q;
    last_blk_d = last_blk_q;
    bcnt_d     = bcnt_q;
    tmr_d      = tmr_q;
    m_digest_d = m_digest_q;
    m_blocks_d = m_blocks_q;
    err_d      = err_q;

    case (state_q)
      ST_COLLECT: begin
        if (bus.s_valid && s_ready_q) begin
          block_d[wcnt_q] = bus.s_data;
          wcnt_d          = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            last_blk_d = bus.s_last;
            state_d    = ST_ISSUE;
          end else if (bus.s_last) begin
            // misplaced end-of-message marker: flag it, keep collecting
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        first_d = 1'b0;
        if (bcnt_q != {CNT_W{1'b1}}) bcnt_d = bcnt_q + 1'b1;
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        // core_ready may still show the pre-pulse idle level here
        tmr_d   = TMR_W'(TIMEOUT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready) begin
          if (last_blk_q) begin
            m_digest_d = core_digest;
            m_blocks_d = bcnt_q;
            if (!core_digest_valid) err_d = 1'b1;
            state_d = ST_OUTPUT;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (tmr_q <= TMR_W'(1)) begin
          // core never came back: drop the message and restart clean
          err_d   = 1'b1;
          first_d = 1'b1;
          bcnt_d  = '0;
          state_d = ST_COLLECT;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (m_valid_q && bus.m_ready) begin
          first_d = 1'b1;
          bcnt_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // outputs are registered, so derive them from the state being entered
    s_ready_d = (state_d == ST_COLLECT);
    m_valid_d = (state_d == ST_OUTPUT);
    init_d    = (state_d == ST_ISSUE) &&  first_q;
    next_d    = (state_d == ST_ISSUE) && !first_q;
    busy_d    = !((state_d == ST_COLLECT) && (wcnt_d == 4'd0) && first_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_COLLECT;
      // NOTE: the word store is reset as well because core_block is a
      // visible output that must read zero out of reset.
      block_q    <= '0;
      wcnt_q     <= '0;
      first_q    <= 1'b1;
      last_blk_q <= 1'b0;
      bcnt_q     <= '0;
      tmr_q      <= '0;
      s_ready_q  <= 1'b0;
      init_q     <= 1'b0;
      next_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_digest_q <= '0;
      m_blocks_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others.
      state_q    <= state_d;
      block_q    <= block_d;
      wcnt_q     <= wcnt_d;
      first_q    <= first_d;
      last_blk_q <= last_blk_d;
      bcnt_q     <= bcnt_d;
      tmr_q      <= tmr_d;
      s_ready_q  <= s_ready_d;
      init_q     <= init_d;
      next_q     <= next_d;
      m_valid_q  <= m_valid_d;
      m_digest_q <= m_digest_d;
      m_blocks_q <= m_blocks_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_digest = m_digest_q;
  assign bus.m_blocks = m_blocks_q;
  assign core_init    = init_q;
  assign core_next    = next_q;
  assign core_block   = block_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
Streaming front-end controller for the sha256 core. It accepts 32-bit message words over a valid/ready stream and packs each 16 words into a 512-bit block. For the first block of a message it issues a single-cycle init; for later blocks it issues next. After the last block it captures the 256-bit digest and presents it on a held valid/ready output. Software or a DMA engine supplies already-padded messages; this block never pads.

Parameters:
TIMEOUT, 1024, max cycles to wait for core_ready after an init/next pulse before flagging error
CNT_W, 16, width of the per-message block counter

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  32  message word, big-endian SHA word order
s_last  in  1  marks final word of message; legal only on word index 15 of a block
core_init  out  1  single-cycle init pulse to sha256 core
core_next  out  1  single-cycle next pulse to sha256 core
core_block  out  512  assembled block; word k at bits [32k+31:32k]
core_ready  in  1  core idle/ready
core_digest  in  256  core digest, H0 at [255:224]
core_digest_valid  in  1  core digest valid
m_valid  out  1  digest available
m_ready  in  1  digest consumer ready
m_digest  out  256  captured digest
m_blocks  out  CNT_W  number of blocks in the hashed message
busy  out  1  high in any state except COLLECT with word count 0 and no pending message
err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset values: s_ready=0, core_init=0, core_next=0, core_block=0, m_valid=0, m_digest=0, m_blocks=0, busy=0, err=0. The FSM enters COLLECT with wcnt=0, first=1, bcnt=0. s_ready rises in the cycle after reset deasserts.
- States: COLLECT, ISSUE, GUARD, WAIT, OUTPUT.
- COLLECT: s_ready=1. On each handshake, s_data is written to word slot wcnt and wcnt increments (4-bit, wraps 15->0).
  - On the handshake of word 15, register last_blk=s_last and go to ISSUE.
  - s_last=1 on any word other than index 15 sets err. That s_last is otherwise ignored and collection continues.
- ISSUE (1 cycle, s_ready=0): if first=1, pulse core_init; otherwise pulse core_next. Then clear first, increment bcnt (saturating at all-ones), and go to GUARD.
- GUARD (1 cycle): core_ready is ignored here to cover core ready-deassert latency. Load the timeout counter with TIMEOUT. Go to WAIT.
- WAIT: when core_ready=1:
  - if last_blk=1: capture m_digest<=core_digest and m_blocks<=bcnt, go to OUTPUT.
  - otherwise return to COLLECT.
  - Otherwise decrement the timer. When it reaches 0, set err, set first=1 and bcnt=0, discard the message, and go to COLLECT.
- core_digest_valid is not used for sequencing. If it is 0 when the last block completes, set err; the digest is still captured.
- OUTPUT: m_valid=1. m_digest and m_blocks stay stable until m_valid&m_ready. On that handshake: m_valid<=0, first<=1, bcnt<=0, go to COLLECT. s_ready=0 throughout OUTPUT, so the next message waits.
- core_block is driven from the word registers. It is stable from ISSUE through the end of WAIT; words are only rewritten in COLLECT.
- Throughput: block done -> next block issued needs 16 accept cycles + ISSUE + GUARD; core latency is added.
- Reset mid-operation: every state drops to the reset values in the next cycle. A pending digest is lost.
- Exactly one of core_init/core_next is high, and only in ISSUE. The two are never asserted together.

Test Plan:
- "abc" padded single block (61626380, 00000000 x14, 00000018, s_last on word 15) -> one core_init, no core_next, m_blocks=1, m_digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block 448-bit message "abcdbcdecdef...nopq" padded, s_last on word 31 -> init then next, m_blocks=2, m_digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-to-back messages with m_ready held 0 for 20 cycles -> m_valid/m_digest stable; s_ready=0 until accept; second message hashes correctly after first=1 restart (init issued).
- s_valid toggling randomly with s_last asserted on word 7 -> err=1; block still assembled correctly from all 16 words; err stays 1 until reset.
- Stub core holding core_ready=0 with TIMEOUT=8 -> err set after 8 WAIT cycles, FSM back in COLLECT with s_ready=1, next block issues core_init.
- wb_rst_i pulsed during WAIT of a 2-block message -> next cycle all outputs zero, no m_valid; following message starts with core_init.
